// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_stage
//  Description : Pipeline writeback stage. Retires ALU, link and load results
//                into the register file (general port plus dedicated r31
//                port), aligns big-endian load data, supports flush and keeps
//                a retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_alu,
    input  logic [31:0]      in_link,
    input  logic [1:0]       in_ld_size,
    input  logic             in_ld_signed,
    input  logic [1:0]       in_addr_lo,
    input  logic             mem_rsp_valid,
    input  logic [31:0]      mem_rdata,
    input  logic             flush,
    output logic             writenable,
    output logic [4:0]       writesel,
    output logic [31:0]      Din,
    output logic             r31_en,
    output logic [31:0]      register31,
    output logic [CNT_W-1:0] retired
);

    localparam logic [1:0] c_KIND_NONE = 2'd0;
    localparam logic [1:0] c_KIND_ALU  = 2'd1;
    localparam logic [1:0] c_KIND_LOAD = 2'd2;
    localparam logic [1:0] c_KIND_LINK = 2'd3;

    localparam logic [1:0] c_SIZE_BYTE = 2'd0;
    localparam logic [1:0] c_SIZE_HALF = 2'd1;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t           state_q,      state_d;
    logic             writenable_q, writenable_d;
    logic [4:0]       writesel_q,   writesel_d;
    logic [31:0]      din_q,        din_d;
    logic             r31_en_q,     r31_en_d;
    logic [31:0]      register31_q, register31_d;
    logic [CNT_W-1:0] retired_q,    retired_d;

    // Load context captured at accept, used when the memory response arrives
    logic [4:0]       ld_rd_q,      ld_rd_d;
    logic [1:0]       ld_size_q,    ld_size_d;
    logic             ld_signed_q,  ld_signed_d;
    logic [1:0]       ld_addr_q,    ld_addr_d;

    logic             w_accept;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load_data;

    assign in_ready   = (state_q == IDLE);
    // A flush in the same cycle kills the incoming instruction
    assign w_accept   = in_valid & in_ready & ~flush;

    assign writenable = writenable_q;
    assign writesel   = writesel_q;
    assign Din        = din_q;
    assign r31_en     = r31_en_q;
    assign register31 = register31_q;
    assign retired    = retired_q;

    // Big-endian lane select and sign/zero extension of the load response.
    // Misaligned halves round down to the half boundary; words ignore addr_lo.
    always_comb begin
        w_byte      = 8'h00;
        w_half      = 16'h0000;
        w_load_data = mem_rdata;
        case (ld_size_q)
            c_SIZE_BYTE: begin
                case (ld_addr_q)
                    2'd0:    w_byte = mem_rdata[31:24];
                    2'd1:    w_byte = mem_rdata[23:16];
                    2'd2:    w_byte = mem_rdata[15:8];
                    default: w_byte = mem_rdata[7:0];
                endcase
                w_load_data = {{24{ld_signed_q & w_byte[7]}}, w_byte};
            end
            c_SIZE_HALF: begin
                w_half      = ld_addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
                w_load_data = {{16{ld_signed_q & w_half[15]}}, w_half};
            end
            default: w_load_data = mem_rdata;
        endcase
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        writenable_d = 1'b0;
        writesel_d   = writesel_q;
        din_d        = din_q;
        r31_en_d     = 1'b0;
        register31_d = register31_q;
        retired_d    = retired_q;
        ld_rd_d      = ld_rd_q;
        ld_size_d    = ld_size_q;
        ld_signed_d  = ld_signed_q;
        ld_addr_d    = ld_addr_q;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    case (in_kind)
                        c_KIND_NONE: begin
                            retired_d = retired_q + c_CNT_ONE;
                        end
                        c_KIND_ALU: begin
                            // r0 is hard-wired zero: retire without a write
                            if (in_rd != 5'd0) begin
                                writenable_d = 1'b1;
                                writesel_d   = in_rd;
                                din_d        = in_alu;
                            end
                            retired_d = retired_q + c_CNT_ONE;
                        end
                        c_KIND_LOAD: begin
                            // Any response already present now is stale
                            ld_rd_d     = in_rd;
                            ld_size_d   = in_ld_size;
                            ld_signed_d = in_ld_signed;
                            ld_addr_d   = in_addr_lo;
                            state_d     = WAIT_MEM;
                        end
                        default: begin
                            r31_en_d     = 1'b1;
                            register31_d = in_link;
                            retired_d    = retired_q + c_CNT_ONE;
                        end
                    endcase
                end
            end
            WAIT_MEM: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (mem_rsp_valid) begin
                    if (ld_rd_q != 5'd0) begin
                        writenable_d = 1'b1;
                        writesel_d   = ld_rd_q;
                        din_d        = w_load_data;
                    end
                    retired_d = retired_q + c_CNT_ONE;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            writenable_q <= 1'b0;
            writesel_q   <= 5'd0;
            din_q        <= 32'd0;
            r31_en_q     <= 1'b0;
            register31_q <= 32'd0;
            retired_q    <= '0;
            ld_rd_q      <= 5'd0;
            ld_size_q    <= 2'd0;
            ld_signed_q  <= 1'b0;
            ld_addr_q    <= 2'd0;
        end else begin
            state_q      <= state_d;
            writenable_q <= writenable_d;
            writesel_q   <= writesel_d;
            din_q        <= din_d;
            r31_en_q     <= r31_en_d;
            register31_q <= register31_d;
            retired_q    <= retired_d;
            ld_rd_q      <= ld_rd_d;
            ld_size_q    <= ld_size_d;
            ld_signed_q  <= ld_signed_d;
            ld_addr_q    <= ld_addr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_stage
//  Description : Directed table-driven bench for writeback_stage, plus
//                hand-written flush and reset sequences. A narrow retired
//                counter is used so the wrap-around is exercised.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_kind;
    logic [4:0]       in_rd;
    logic [31:0]      in_alu;
    logic [31:0]      in_link;
    logic [1:0]       in_ld_size;
    logic             in_ld_signed;
    logic [1:0]       in_addr_lo;
    logic             mem_rsp_valid;
    logic [31:0]      mem_rdata;
    logic             flush;
    logic             writenable;
    logic [4:0]       writesel;
    logic [31:0]      Din;
    logic             r31_en;
    logic [31:0]      register31;
    logic [CNT_W-1:0] retired;

    int n_checks = 0;
    int n_errors = 0;

    // Expected architectural state
    logic [31:0]      m_din;
    logic [31:0]      m_r31;
    logic [4:0]       m_sel;
    logic [CNT_W-1:0] m_ret;

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] link;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  addr;
        logic [31:0] rdata;
        int          waits;
        logic        exp_we;
        logic        exp_r31en;
        logic [31:0] exp_val;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    writeback_stage #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_kind      (in_kind),
        .in_rd        (in_rd),
        .in_alu       (in_alu),
        .in_link      (in_link),
        .in_ld_size   (in_ld_size),
        .in_ld_signed (in_ld_signed),
        .in_addr_lo   (in_addr_lo),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata    (mem_rdata),
        .flush        (flush),
        .writenable   (writenable),
        .writesel     (writesel),
        .Din          (Din),
        .r31_en       (r31_en),
        .register31   (register31),
        .retired      (retired)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".writenable"}, {31'd0, writenable}, 32'd0);
        check({tag, ".r31_en"},     {31'd0, r31_en},     32'd0);
        check({tag, ".Din"},        Din,                 m_din);
        check({tag, ".writesel"},   {27'd0, writesel},   {27'd0, m_sel});
        check({tag, ".register31"}, register31,          m_r31);
        check({tag, ".retired"},    {28'd0, retired},    {28'd0, m_ret});
    endtask

    task automatic clear_inputs();
        in_valid      = 1'b0;
        in_kind       = 2'd0;
        in_rd         = 5'd0;
        in_alu        = 32'h5A5A5A5A;
        in_link       = 32'hA5A5A5A5;
        in_ld_size    = 2'd0;
        in_ld_signed  = 1'b0;
        in_addr_lo    = 2'd0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'd0;
        flush         = 1'b0;
    endtask

    // Entered and left on a falling edge
    task automatic apply(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        check({tag, ".ready_in"}, {31'd0, in_ready}, 32'd1);
        in_valid     = 1'b1;
        in_kind      = v.kind;
        in_rd        = v.rd;
        in_alu       = v.alu;
        in_link      = v.link;
        in_ld_size   = v.size;
        in_ld_signed = v.sgn;
        in_addr_lo   = v.addr;
        if (v.kind == 2'd2) begin
            // Stale response in the accept cycle must be ignored
            mem_rsp_valid = 1'b1;
            mem_rdata     = 32'hFFFFFFFF;
        end
        @(negedge clk);
        clear_inputs();
        if (v.kind == 2'd2) begin
            for (int w = 0; w < v.waits; w++) begin
                check($sformatf("%s.wait%0d_ready", tag, w), {31'd0, in_ready}, 32'd0);
                check($sformatf("%s.wait%0d_we", tag, w), {31'd0, writenable}, 32'd0);
                @(negedge clk);
            end
            check({tag, ".rsp_ready"}, {31'd0, in_ready}, 32'd0);
            mem_rsp_valid = 1'b1;
            mem_rdata     = v.rdata;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_rdata     = 32'd0;
        end
        m_ret = m_ret + 1'b1;
        if (v.exp_we) begin
            m_din = v.exp_val;
            m_sel = v.rd;
        end
        if (v.exp_r31en) m_r31 = v.exp_val;
        check({tag, ".writenable"}, {31'd0, writenable}, {31'd0, v.exp_we});
        check({tag, ".r31_en"},     {31'd0, r31_en},     {31'd0, v.exp_r31en});
        check({tag, ".writesel"},   {27'd0, writesel},   {27'd0, m_sel});
        check({tag, ".Din"},        Din,                 m_din);
        check({tag, ".register31"}, register31,          m_r31);
        check({tag, ".retired"},    {28'd0, retired},    {28'd0, m_ret});
        check({tag, ".ready_wb"},   {31'd0, in_ready},   32'd1);
        @(negedge clk);
        check({tag, ".we_drop"},    {31'd0, writenable}, 32'd0);
        check({tag, ".r31_drop"},   {31'd0, r31_en},     32'd0);
    endtask

    initial begin
        vec_t fin;
        //          kind  rd     alu           link          sz    sgn   addr  rdata         w  we    r31   value
        vecs[0]  = '{2'd1, 5'd5,  32'h12345678, 32'h0,        2'd0, 1'b0, 2'd0, 32'h0,        0, 1'b1, 1'b0, 32'h12345678};
        vecs[1]  = '{2'd3, 5'd0,  32'h0,        32'h00000104, 2'd0, 1'b0, 2'd0, 32'h0,        0, 1'b0, 1'b1, 32'h00000104};
        vecs[2]  = '{2'd1, 5'd0,  32'hDEADBEEF, 32'h0,        2'd0, 1'b0, 2'd0, 32'h0,        0, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{2'd0, 5'd3,  32'h11111111, 32'h22222222, 2'd0, 1'b0, 2'd0, 32'h0,        0, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{2'd2, 5'd7,  32'h0,        32'h0,        2'd0, 1'b1, 2'd1, 32'h00F00000, 3, 1'b1, 1'b0, 32'hFFFFFFF0};
        vecs[5]  = '{2'd2, 5'd8,  32'h0,        32'h0,        2'd0, 1'b0, 2'd1, 32'h00F00000, 0, 1'b1, 1'b0, 32'h000000F0};
        vecs[6]  = '{2'd2, 5'd9,  32'h0,        32'h0,        2'd0, 1'b0, 2'd0, 32'hA1B2C3D4, 1, 1'b1, 1'b0, 32'h000000A1};
        vecs[7]  = '{2'd2, 5'd10, 32'h0,        32'h0,        2'd0, 1'b1, 2'd3, 32'hA1B2C3D4, 0, 1'b1, 1'b0, 32'hFFFFFFD4};
        vecs[8]  = '{2'd2, 5'd11, 32'h0,        32'h0,        2'd0, 1'b0, 2'd2, 32'h11228344, 2, 1'b1, 1'b0, 32'h00000083};
        vecs[9]  = '{2'd2, 5'd12, 32'h0,        32'h0,        2'd1, 1'b1, 2'd0, 32'hA1B2C3D4, 0, 1'b1, 1'b0, 32'hFFFFA1B2};
        vecs[10] = '{2'd2, 5'd13, 32'h0,        32'h0,        2'd1, 1'b0, 2'd2, 32'hA1B2C3D4, 1, 1'b1, 1'b0, 32'h0000C3D4};
        vecs[11] = '{2'd2, 5'd14, 32'h0,        32'h0,        2'd1, 1'b0, 2'd3, 32'hA1B2C3D4, 0, 1'b1, 1'b0, 32'h0000C3D4};
        vecs[12] = '{2'd2, 5'd15, 32'h0,        32'h0,        2'd1, 1'b1, 2'd1, 32'hA1B2C3D4, 0, 1'b1, 1'b0, 32'hFFFFA1B2};
        vecs[13] = '{2'd2, 5'd16, 32'h0,        32'h0,        2'd1, 1'b1, 2'd0, 32'h7F001234, 0, 1'b1, 1'b0, 32'h00007F00};
        vecs[14] = '{2'd2, 5'd17, 32'h0,        32'h0,        2'd2, 1'b1, 2'd0, 32'hA1B2C3D4, 0, 1'b1, 1'b0, 32'hA1B2C3D4};
        vecs[15] = '{2'd2, 5'd18, 32'h0,        32'h0,        2'd2, 1'b0, 2'd3, 32'h89ABCDEF, 1, 1'b1, 1'b0, 32'h89ABCDEF};
        vecs[16] = '{2'd2, 5'd0,  32'h0,        32'h0,        2'd2, 1'b0, 2'd0, 32'hCAFEF00D, 0, 1'b0, 1'b0, 32'h0};
        vecs[17] = '{2'd1, 5'd31, 32'h0BADF00D, 32'h0,        2'd0, 1'b0, 2'd0, 32'h0,        0, 1'b1, 1'b0, 32'h0BADF00D};

        clear_inputs();
        rst   = 1'b1;
        m_din = 32'd0;
        m_r31 = 32'd0;
        m_sel = 5'd0;
        m_ret = '0;
        @(negedge clk);
        @(negedge clk);
        check_state("reset");
        check("reset.ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        check("post_reset.ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < NVEC; i++) apply(vecs[i], i);

        // Flush in IDLE: the offered instruction is dropped
        in_valid = 1'b1; in_kind = 2'd1; in_rd = 5'd9; in_alu = 32'h00000055;
        flush    = 1'b1;
        @(negedge clk);
        clear_inputs();
        check_state("flush_idle");
        check("flush_idle.ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check_state("flush_idle_next");

        // Flush in WAIT_MEM together with a response
        in_valid = 1'b1; in_kind = 2'd2; in_rd = 5'd20; in_ld_size = 2'd2;
        @(negedge clk);
        clear_inputs();
        check("flush_wait.ready_wait", {31'd0, in_ready}, 32'd0);
        flush = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'h12121212;
        @(negedge clk);
        clear_inputs();
        check_state("flush_wait");
        check("flush_wait.ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check_state("flush_wait_next");

        // Asynchronous reset in the middle of a load
        in_valid = 1'b1; in_kind = 2'd2; in_rd = 5'd21; in_ld_size = 2'd2;
        @(negedge clk);
        clear_inputs();
        check("rst_mid.ready_wait", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        m_din = 32'd0; m_r31 = 32'd0; m_sel = 5'd0; m_ret = '0;
        check_state("rst_mid_async");
        check("rst_mid_async.ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_release.ready", {31'd0, in_ready}, 32'd1);
        mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        clear_inputs();
        check_state("rst_mid_late_rsp");
        @(negedge clk);
        check_state("rst_mid_late_rsp_next");

        // Normal operation resumes after the abandoned load
        fin = '{2'd1, 5'd3, 32'h0000600D, 32'h0, 2'd0, 1'b0, 2'd0, 32'h0, 0, 1'b1, 1'b0, 32'h0000600D};
        apply(fin, 99);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter: CNT_W, 32, width of retired-instruction counter.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; ports named clk and rst.
REQ-003 clk  in  1  rising-edge clock shared with the register file.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 in_valid  in  1  MEM stage presents an instruction.
REQ-006 in_ready  out  1  block accepts it this cycle (accept = in_valid & in_ready).
REQ-007 in_kind  in  2  0=no write, 1=ALU result, 2=load, 3=link (JAL/JALR).
REQ-008 in_rd  in  5  destination register.
REQ-009 in_alu  in  32  ALU result (kind 1).
REQ-010 in_link  in  32  return address (kind 3).
REQ-011 in_ld_size  in  2  0=byte, 1=half, 2=word.
REQ-012 in_ld_signed  in  1  sign-extend sub-word load.
REQ-013 in_addr_lo  in  2  load address bits [1:0].
REQ-014 mem_rsp_valid  in  1  data memory read data valid.
REQ-015 mem_rdata  in  32  data memory read data.
REQ-016 flush  in  1  kill pending and incoming instruction.
REQ-017 writenable, writesel[4:0], Din[31:0]  out  general register write port.
REQ-018 r31_en, register31[31:0]  out  dedicated link-register write port.
REQ-019 retired  out  CNT_W  count of completed instructions.

Function
REQ-020 States: IDLE, WAIT_MEM; in_ready SHALL be 1 in IDLE, 0 in WAIT_MEM.
REQ-021 Accept of kind 0/1/3 in IDLE: outputs registered, write asserted exactly one cycle, cycle after accept edge; state stays IDLE.
REQ-022 Kind 1: writenable=1, writesel=in_rd, Din=in_alu; kind 3: r31_en=1, register31=in_link, writenable=0.
REQ-023 Kind 0: no write strobes; still counts as retired.
REQ-024 in_rd==0 with kind 1 or 2: writenable SHALL stay 0 (r0 never written); instruction still retired.
REQ-025 Accept of kind 2: capture rd/size/signed/addr_lo, go WAIT_MEM; mem_rsp_valid already high in the accept cycle is ignored.
REQ-026 In WAIT_MEM, on mem_rsp_valid: align data, writenable=1 next cycle, return to IDLE; in_ready=1 again in that write cycle.
REQ-027 Alignment big-endian: byte lane k (addr_lo=k) = mem_rdata[31-8k:24-8k]; half at addr_lo 0 = [31:16], 2 = [15:0]; word ignores addr_lo.
REQ-028 Sub-word SHALL be zero-extended unless in_ld_signed, then sign-extended to 32 bits.
REQ-029 Misaligned half (addr_lo odd) or word (addr_lo!=0): use addr_lo&2'b10 / 0 respectively; no error flag.
REQ-030 flush in IDLE: same-cycle in_valid is not accepted, nothing written, not retired.
REQ-031 flush in WAIT_MEM: return to IDLE, no write, not retired, even if mem_rsp_valid same cycle.
REQ-032 retired increments by 1 in the cycle each write strobe (or kind-0 completion) is issued; wraps at 2^CNT_W.
REQ-033 writenable and r31_en SHALL never be high together; Din/register31 hold last value when strobes low.

Reset
REQ-034 rst SHALL force IDLE, writenable=0, r31_en=0, writesel=0, Din=0, register31=0, retired=0 immediately, independent of clk.
REQ-035 rst during WAIT_MEM SHALL abandon the load; a later mem_rsp_valid in IDLE SHALL be ignored.
REQ-036 After rst deasserts, in_ready=1 in the first cycle.

Verification
REQ-037 ALU: kind1, rd=5, in_alu=0x12345678 -> next cycle writenable=1, writesel=5, Din=0x12345678, retired=1.
REQ-038 Signed byte: kind2, size0, signed, addr_lo=1, mem_rdata=0x00F00000 after 3 wait cycles -> in_ready=0 for 4 cycles, then Din=0xFFFFFFF0, writesel=rd.
REQ-039 Link: kind3, in_link=0x00000104 -> r31_en=1, register31=0x104, writenable=0.
REQ-040 rd=0: kind1, in_alu=0xDEADBEEF -> writenable stays 0, retired increments.
REQ-041 Flush: load accepted, flush asserted with mem_rsp_valid -> no write, retired unchanged, in_ready=1 next cycle.
REQ-042 Reset mid-load: rst during WAIT_MEM, then mem_rsp_valid -> all outputs 0, no write.
